// File: rtl/tone_event_controller.sv
// rtl/tone_event_controller.sv - prioritised sound-event tone sequencer with play/gap timing
// Optional feature: define TONE_QUEUE_EN to hold one lower-priority request for playback after the gap.
module tone_event_controller #(
  parameter int N_EVT     = 4,
  parameter int BASE_DIV  = 50000,
  parameter int DUR_TICKS = 4,
  parameter int GAP_TICKS = 2,
  localparam int IDW      = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slowen,
  input  logic [N_EVT-1:0] evt,
  output logic             audio,
  output logic             gain,
  output logic             notshutdown,
  output logic             busy,
  output logic [IDW-1:0]   active_id
);

  localparam int DIVW = (BASE_DIV > 1) ? $clog2(BASE_DIV + 1) : 1;
  localparam int DW   = $clog2(DUR_TICKS * N_EVT + 1);
  localparam int GW   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            audio_q, audio_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            pend_valid_q, pend_valid_d;
  logic [IDW-1:0]  pend_id_q, pend_id_d;

  logic            evt_any;
  logic [IDW-1:0]  evt_hi;
  logic            preempt;
  logic            start;
  logic [IDW-1:0]  start_id;
  logic            end_play;
  logic            exit_gap;

  // Find the highest requesting event and whether it outranks the current sound
  always_comb begin
    evt_any = |evt;
    evt_hi  = '0;
    for (int i = 0; i < N_EVT; i++) begin
      if (evt[i]) evt_hi = IDW'(i);
    end
    preempt = evt_any && (evt_hi > id_q);
  end

  // Next-state logic: event selection, tone divider, play and gap tick counting
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    dur_d        = dur_q;
    gap_d        = gap_q;
    audio_d      = audio_q;
    id_d         = id_q;
    pend_valid_d = pend_valid_q;
    pend_id_d    = pend_id_q;
    start        = 1'b0;
    start_id     = evt_hi;
    end_play     = 1'b0;
    exit_gap     = 1'b0;

`ifdef TONE_QUEUE_EN
    // Non-preempting requests while sounding are remembered, keeping the highest index
    if (state_q != S_IDLE && evt_any && !preempt &&
        (!pend_valid_q || evt_hi > pend_id_q)) begin
      pend_valid_d = 1'b1;
      pend_id_d    = evt_hi;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (evt_any) start = 1'b1;
      end
      S_PLAY: begin
        if (preempt) begin
          start = 1'b1;
        end else if (slowen && dur_q == DW'(1)) begin
          end_play = 1'b1;
        end else begin
          if (slowen) dur_d = dur_q - DW'(1);
          if (div_q == DIVW'(1)) begin
            audio_d = ~audio_q;
            div_d   = DIVW'(BASE_DIV >> id_q);
          end else begin
            div_d = div_q - DIVW'(1);
          end
        end
      end
      S_GAP: begin
        if (preempt) begin
          start = 1'b1;
        end else if (slowen) begin
          if (gap_q == GW'(1)) exit_gap = 1'b1;
          else gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_play) begin
      audio_d = 1'b0;
      div_d   = '0;
      dur_d   = '0;
      if (GAP_TICKS == 0) begin
        exit_gap = 1'b1;
      end else begin
        state_d = S_GAP;
        gap_d   = GW'(GAP_TICKS);
      end
    end

    if (exit_gap) begin
      state_d = S_IDLE;
      gap_d   = '0;
      if (pend_valid_d) begin
        start        = 1'b1;
        start_id     = pend_id_d;
        pend_valid_d = 1'b0;
        pend_id_d    = '0;
      end
    end

    if (start) begin
      state_d = S_PLAY;
      id_d    = start_id;
      div_d   = DIVW'(BASE_DIV >> start_id);
      dur_d   = DW'(DUR_TICKS * (int'(start_id) + 1));
      gap_d   = '0;
      audio_d = 1'b0;
    end
  end

  // State registers with immediate silencing on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      dur_q        <= '0;
      gap_q        <= '0;
      audio_q      <= 1'b0;
      id_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      dur_q        <= dur_d;
      gap_q        <= gap_d;
      audio_q      <= audio_d;
      id_q         <= id_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
    end
  end

  assign audio       = audio_q;
  assign gain        = 1'b1;
  assign notshutdown = (state_q != S_IDLE);
  assign busy        = notshutdown;
  assign active_id   = id_q;

endmodule

// File: tb/tb_tone_event_controller.sv
// tb/tb_tone_event_controller.sv - randomized and directed checks of tone_event_controller against a behavioural model
module tb_tone_event_controller;

  localparam int N   = 4;
  localparam int BD  = 8;
  localparam int DUR = 2;
  localparam int GAP = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         slowen = 1'b0;
  logic [N-1:0] evt = '0;
  logic         audio, gain, notshutdown, busy;
  logic [1:0]   active_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  tone_event_controller #(
    .N_EVT(N), .BASE_DIV(BD), .DUR_TICKS(DUR), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .evt(evt),
    .audio(audio), .gain(gain), .notshutdown(notshutdown),
    .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 sounding, 2 silent gap
  int m_mode = 0, m_id = 0, m_el = 0, m_left = 0, m_gleft = 0, m_pid = 0;
  bit m_pend = 0;

  function automatic int hi_idx(logic [N-1:0] e);
    int h = -1;
    for (int i = 0; i < N; i++) if (e[i]) h = i;
    return h;
  endfunction

  task automatic m_start(int i);
    m_mode = 1; m_id = i; m_el = 0; m_left = DUR * (i + 1);
  endtask

  task automatic m_exit();
    if (m_pend) begin
      m_pend = 0; m_start(m_pid);
    end else begin
      m_mode = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_id = 0; m_el = 0; m_left = 0; m_gleft = 0; m_pend = 0; m_pid = 0;
    end else begin
      int h;
      h = hi_idx(evt);
      if (m_mode == 0) begin
        if (h >= 0) m_start(h);
      end else if (h > m_id) begin
        m_start(h);
      end else begin
`ifdef TONE_QUEUE_EN
        if (h >= 0 && (!m_pend || h > m_pid)) begin m_pend = 1; m_pid = h; end
`endif
        if (m_mode == 1) begin
          if (slowen) m_left--;
          if (m_left == 0) begin
            if (GAP == 0) m_exit();
            else begin m_mode = 2; m_gleft = GAP; end
          end else begin
            m_el++;
          end
        end else begin
          if (slowen) begin
            m_gleft--;
            if (m_gleft == 0) m_exit();
          end
        end
      end
    end
  end

  function automatic int m_audio();
    if (m_mode != 1) return 0;
    return (m_el / (BD >> m_id)) % 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (started) begin
      chk("audio", {31'd0, audio}, m_audio());
      chk("busy", {31'd0, busy}, (m_mode != 0) ? 1 : 0);
      chk("notshutdown", {31'd0, notshutdown}, (m_mode != 0) ? 1 : 0);
      chk("active_id", {30'd0, active_id}, m_id);
      chk("gain", {31'd0, gain}, 1);
    end
  end

  task automatic step(input logic [N-1:0] e, input logic r);
    @(posedge clk);
    #1;
    evt = e;
    rst = r;
    cyc++;
    slowen = (cyc % 100 == 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      step('0, 1'b0);
      n++;
    end
    chk(name, {31'd0, busy}, 0);
  endtask

  initial begin
    repeat (3) step('0, 1'b1);
    started = 1'b1;
    chk("rst_audio", {31'd0, audio}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_nshdn", {31'd0, notshutdown}, 0);
    chk("rst_id", {30'd0, active_id}, 0);
    chk("rst_gain", {31'd0, gain}, 1);
    step('0, 1'b0);

    // Event 0: half-period 8, then gap, then idle
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    chk("e0_busy", {31'd0, busy}, 1);
    chk("e0_id", {30'd0, active_id}, 0);
    chk("e0_audio_k0", {31'd0, audio}, 0);
    repeat (7) step('0, 1'b0);
    chk("e0_audio_k7", {31'd0, audio}, 0);
    step('0, 1'b0);
    chk("e0_audio_k8", {31'd0, audio}, 1);
    wait_idle("e0_idle");

    // Multiple bits: highest wins, half-period 1
    step(4'b1010, 1'b0);
    step('0, 1'b0);
    chk("e3_id", {30'd0, active_id}, 3);
    chk("e3_audio_k0", {31'd0, audio}, 0);
    step('0, 1'b0);
    chk("e3_audio_k1", {31'd0, audio}, 1);
    step('0, 1'b0);
    chk("e3_audio_k2", {31'd0, audio}, 0);
    wait_idle("e3_idle");

    // Preempt coinciding with slowen
    for (int n = 0; n < 100 && (cyc % 100) != 10; n++) step('0, 1'b0);
    step(4'b0001, 1'b0);
    for (int n = 0; n < 100 && ((cyc + 1) % 100) != 0; n++) step('0, 1'b0);
    step(4'b0100, 1'b0);
    chk("pre_slowen", {31'd0, slowen}, 1);
    step('0, 1'b0);
    chk("pre_id", {30'd0, active_id}, 2);
    chk("pre_audio_k0", {31'd0, audio}, 0);
    step('0, 1'b0);
    chk("pre_audio_k1", {31'd0, audio}, 0);
    step('0, 1'b0);
    chk("pre_audio_k2", {31'd0, audio}, 1);
    wait_idle("pre_idle");

    // Lower-priority request while playing
    step(4'b0100, 1'b0);
    repeat (5) step('0, 1'b0);
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    chk("low_id_hold", {30'd0, active_id}, 2);
    wait_idle("low_idle");
`ifdef TONE_QUEUE_EN
    chk("low_final_id", {30'd0, active_id}, 0);
`else
    chk("low_final_id", {30'd0, active_id}, 2);
`endif

    // Asynchronous reset mid-play
    step(4'b1000, 1'b0);
    repeat (5) step('0, 1'b0);
    chk("rp_busy_before", {31'd0, busy}, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
    slowen = (cyc % 100 == 0);
    #1;
    chk("rp_audio", {31'd0, audio}, 0);
    chk("rp_nshdn", {31'd0, notshutdown}, 0);
    chk("rp_busy", {31'd0, busy}, 0);
    chk("rp_gain", {31'd0, gain}, 1);
    chk("rp_id", {30'd0, active_id}, 0);
    step('0, 1'b1);
    step('0, 1'b0);
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    chk("rp_restart", {31'd0, busy}, 1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 20000; n++) begin
      logic [N-1:0] e;
      e = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      step(e, ($urandom_range(0, 2999) == 0) ? 1'b1 : 1'b0);
    end
    step('0, 1'b0);
    step('0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_event_controller.md
TONE_EVENT_CONTROLLER -- requirements
Module: tone_event_controller

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  N_EVT, 4, number of sound event inputs; index N_EVT-1 has highest priority.
  BASE_DIV, 50000, half-period in clk cycles of event 0's tone; event i uses BASE_DIV>>i.
  DUR_TICKS, 4, event i plays DUR_TICKS*(i+1) slowen ticks.
  GAP_TICKS, 2, silent slowen ticks after each sound.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 slowen  input  1  one-clk-wide slow time-base tick.
REQ-005 evt  input  N_EVT  sound request pulses; bit i requests event i.
REQ-006 audio  output  1  square-wave tone to amplifier.
REQ-007 gain  output  1  amplifier gain select; constant 1 (6 dB).
REQ-008 notshutdown  output  1  amplifier enable.
REQ-009 busy  output  1  high in PLAY or GAP.
REQ-010 active_id  output  clog2(N_EVT)  index of the event playing or last played.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, PLAY, GAP.
REQ-012 In IDLE, any evt bit high at a clk edge SHALL select the highest set index, load the tone divider and the duration counter, and enter PLAY on that edge.
REQ-013 In PLAY, audio SHALL start at 0 and toggle every BASE_DIV>>active_id clk cycles; the first toggle comes BASE_DIV>>active_id cycles after PLAY entry.
REQ-014 In PLAY, each slowen SHALL decrement the duration counter; the slowen that takes it from 1 to 0 SHALL enter GAP with audio forced to 0.
REQ-015 In PLAY, an evt bit with index greater than active_id SHALL preempt: it reloads the divider, duration counter, and active_id, resets audio to 0, and stays in PLAY. This takes priority over a same-cycle slowen.
REQ-016 In PLAY or GAP, an evt bit with index less than or equal to active_id SHALL be handled per REQ-024/REQ-025.
REQ-017 GAP SHALL last GAP_TICKS slowen ticks, then go to IDLE or to a pending event (REQ-024).
REQ-018 In GAP, a higher-index evt SHALL enter PLAY immediately, as in REQ-015.
REQ-019 notshutdown SHALL be 1 in PLAY and GAP and 0 in IDLE; busy SHALL equal notshutdown.
REQ-020 Divider and counters SHALL be sized by clog2 of their maximum load; no wrap-around occurs in legal operation. GAP_TICKS=0 SHALL cause GAP to be skipped, so the FSM goes PLAY to IDLE directly.

Reset
REQ-021 When rst is asserted, the block SHALL immediately force: state IDLE, audio 0, notshutdown 0, busy 0, active_id 0, all counters 0, pending cleared.
REQ-022 Reset asserted mid-PLAY SHALL silence audio with no further toggles; after release, evt is sampled on the first clk edge.
REQ-023 gain SHALL be 1 during and after reset.

Configuration
REQ-024 With macro TONE_QUEUE_EN defined, a lower- or equal-index evt arriving in PLAY or GAP SHALL be held in a one-deep pending register (highest index kept) and played on GAP exit instead of returning to IDLE.
REQ-025 With TONE_QUEUE_EN undefined, such requests SHALL be dropped, and GAP always exits to IDLE.

Verification
Bench parameters: N_EVT=4, BASE_DIV=8, DUR_TICKS=2, GAP_TICKS=1, slowen every 100 clk cycles.
REQ-026 evt=0001 in IDLE -> PLAY next edge, audio toggles every 8 clks, GAP after 2 slowen ticks, IDLE after 1 more, notshutdown high throughout PLAY and GAP.
REQ-027 evt=1010 in one cycle -> active_id=3, half-period 1 clk, 8 slowen ticks of play.
REQ-028 evt=0001 then evt=0100 mid-PLAY, same cycle as slowen -> active_id=2, duration reloaded to 6, half-period 2, audio restarts at 0.
REQ-029 evt=0100 playing, evt=0001 arrives -> without TONE_QUEUE_EN: dropped, IDLE after GAP; with TONE_QUEUE_EN: event 0 plays after GAP.
REQ-030 rst pulsed mid-PLAY -> audio=0, notshutdown=0, busy=0 within same cycle, IDLE; gain stays 1.
